// File: rtl/dm_pkg.sv
// Shared constants, state encoding and lane-merge helper for the byte-enabled data memory.
package dm_pkg;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dm_state_t;

    // Replace each enabled byte lane of old with the matching lane of wdata.
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (byteen[k]) begin
                r[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge of store data into the currently stored word.
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  byteen_i,
    output logic [31:0] merged_c
);

    assign merged_c = byte_merge(old_i, wdata_i, byteen_i);

endmodule

// File: rtl/dm_byteen_mem.sv
// M-stage data memory: lane-merged stores, combinational loads, clear walker on reset,
// and a registered store-trace record.
module dm_byteen_mem
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        init_busy,
    output logic        oor_err,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0]      mem_q [DEPTH];
    dm_state_t        state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      rd_word;
    logic [31:0]      merged;

    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;
    logic             store;
    logic             oor_d;

    logic             trace_valid_q;
    logic [31:0]      trace_pc_q, trace_addr_q, trace_data_q;
    logic             oor_err_q;

    assign idx          = m_data_addr[IDX_W+1:2];
    assign in_range     = (m_data_addr >> (IDX_W + 2)) == 32'h0;
    assign rd_word      = mem_q[idx];
    assign m_data_rdata = in_range ? rd_word : 32'h0;
    assign init_busy    = (state_q == CLEAR);

    dm_byte_merge u_merge (
        .old_i    (rd_word),
        .wdata_i  (m_data_wdata),
        .byteen_i (m_data_byteen),
        .merged_c (merged)
    );

    // Next state, clear walker and store qualification; reset overrides everything.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_wdata = merged;
        store     = 1'b0;
        oor_d     = 1'b0;
        if (reset) begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_widx  = clr_ptr_q;
                    mem_wdata = 32'h0;
                    clr_ptr_d = clr_ptr_q + IDX_W'(1);
                    if (clr_ptr_q == LAST_IDX) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (m_data_byteen != BYTEEN_NONE) begin
                        if (in_range) begin
                            store  = 1'b1;
                            mem_we = 1'b1;
                        end else begin
                            oor_d = 1'b1;
                        end
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_ptr_q <= clr_ptr_d;
    end

    // Array has no reset of its own; the walker clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // Trace payload holds its last value between committed stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0;
            trace_addr_q  <= 32'h0;
            trace_data_q  <= 32'h0;
            oor_err_q     <= 1'b0;
        end else begin
            trace_valid_q <= store;
            oor_err_q     <= oor_d;
            if (store) begin
                trace_pc_q   <= m_inst_addr;
                trace_addr_q <= m_data_addr & 32'hFFFF_FFFC;
                trace_data_q <= merged;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
    assign oor_err     = oor_err_q;

endmodule

// File: tb/tb_dm_byteen_mem.sv
// Directed self-checking bench for dm_byteen_mem.
module tb_dm_byteen_mem;
    import dm_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        init_busy;
    logic        oor_err;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    int checks   = 0;
    int failures = 0;
    int n;

    dm_byteen_mem dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .init_busy     (init_busy),
        .oor_err       (oor_err),
        .trace_valid   (trace_valid),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        m_inst_addr   = pc;
    endtask

    task automatic idle();
        m_data_byteen = BYTEEN_NONE;
    endtask

    // Count edges after reset release until init_busy drops (bounded).
    task automatic count_clear(output int cycles);
        cycles = 0;
        while (init_busy === 1'b1 && cycles < 10000) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, BYTEEN_NONE, 32'h0);

        // Power-up reset and first clear.
        repeat (5) tick();
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_trace_valid", 32'(trace_valid), 32'd0);
        check("rst_oor_err", 32'(oor_err), 32'd0);
        check("rst_trace_data", trace_data, 32'h0);
        check("rst_trace_pc", trace_pc, 32'h0);
        reset = 1'b0;
        count_clear(n);
        check("boot_clear_cycles", 32'(n), 32'd4096);

        // Preload garbage through the store port.
        drive(32'h0000_3FFC, 32'hA5A5_A5A5, BYTEEN_WORD, 32'h100); tick();
        drive(32'h0000_0008, 32'h5A5A_5A5A, BYTEEN_WORD, 32'h104); tick();
        drive(32'h0000_0020, 32'hFFFF_FFFF, BYTEEN_WORD, 32'h108); tick();
        idle();
        drive(32'h0000_3FFC, 32'h0, BYTEEN_NONE, 32'h0); #1;
        check("preload_visible", m_data_rdata, 32'hA5A5_A5A5);

        // Reset cycle count.
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        count_clear(n);
        check("clear_cycles", 32'(n), 32'd4096);
        check("clear_done_busy", 32'(init_busy), 32'd0);
        drive(32'h0000_3FFC, 32'h0, BYTEEN_NONE, 32'h0); #1;
        check("read_3ffc_cleared", m_data_rdata, 32'h0);

        // Word store.
        drive(32'h0000_0010, 32'hDEAD_BEEF, BYTEEN_WORD, 32'h0000_3004);
        tick();
        idle();
        check("word_trace_valid", 32'(trace_valid), 32'd1);
        check("word_trace_pc", trace_pc, 32'h0000_3004);
        check("word_trace_addr", trace_addr, 32'h0000_0010);
        check("word_trace_data", trace_data, 32'hDEAD_BEEF);
        check("word_rdata", m_data_rdata, 32'hDEAD_BEEF);

        // Lane merges, back to back on the same word.
        drive(32'h0000_0011, 32'h0000_AA00, 4'b0010, 32'h0000_3008);
        tick();
        check("lane1_trace_data", trace_data, 32'hDEAD_AAEF);
        check("lane1_trace_addr", trace_addr, 32'h0000_0010);
        check("lane1_trace_pc", trace_pc, 32'h0000_3008);
        drive(32'h0000_0010, 32'h1234_0000, 4'b1100, 32'h0000_300C);
        tick();
        idle();
        check("lane23_trace_valid", 32'(trace_valid), 32'd1);
        check("lane23_trace_data", trace_data, 32'h1234_AAEF);
        check("lane23_trace_addr", trace_addr, 32'h0000_0010);
        check("lane23_rdata", m_data_rdata, 32'h1234_AAEF);
        tick();
        check("idle_trace_valid", 32'(trace_valid), 32'd0);
        check("idle_trace_hold", trace_data, 32'h1234_AAEF);

        // Out of range.
        drive(32'h0000_4000, 32'hCAFE_F00D, BYTEEN_WORD, 32'h0000_3010);
        #1;
        check("oor_rdata", m_data_rdata, 32'h0);
        tick();
        idle();
        check("oor_pulse", 32'(oor_err), 32'd1);
        check("oor_trace_valid", 32'(trace_valid), 32'd0);
        check("oor_trace_hold", trace_data, 32'h1234_AAEF);
        tick();
        check("oor_pulse_end", 32'(oor_err), 32'd0);
        drive(32'h0000_0000, 32'h0, BYTEEN_NONE, 32'h0); #1;
        check("oor_word0", m_data_rdata, 32'h0);

        // Same-cycle read sees old data.
        drive(32'h0000_0020, 32'h0000_0055, 4'b0001, 32'h0000_3014);
        #1;
        check("samecyc_old", m_data_rdata, 32'h0);
        tick();
        idle();
        check("samecyc_new", m_data_rdata, 32'h0000_0055);
        check("samecyc_trace", trace_data, 32'h0000_0055);

        // Store during clear, then reset mid-clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        tick();
        tick();
        drive(32'h0000_0008, 32'h7777_7777, BYTEEN_WORD, 32'h0000_3018);
        tick();
        idle();
        check("clr_store_trace", 32'(trace_valid), 32'd0);
        check("clr_store_oor", 32'(oor_err), 32'd0);
        check("clr_store_busy", 32'(init_busy), 32'd1);
        repeat (97) tick();
        check("clr_mid_busy", 32'(init_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_clear(n);
        check("restart_clear_cycles", 32'(n), 32'd4096);
        drive(32'h0000_0008, 32'h0, BYTEEN_NONE, 32'h0); #1;
        check("clr_word8", m_data_rdata, 32'h0);
        drive(32'h0000_0010, 32'h0, BYTEEN_NONE, 32'h0); #1;
        check("clr_word10", m_data_rdata, 32'h0);
        check("clr_trace_valid", 32'(trace_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
